uart_lcd_text_bridge: RTL and testbench



---
 rtl/lcd_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_lcd_text_bridge.sv | 166 ++++++++++++++++
 tb/tb_uart_lcd_text_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 and ASCII constants, plus the text-bridge FSM state encoding.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_CHAR   = 3'd3,
    ST_CLEAR  = 3'd4
  } lcd_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full    = (level_r == LW'(DEPTH));
  assign empty   = (level_r == {LW{1'b0}});
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;

  // Storage array; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_lcd_text_bridge.sv
// Buffers UART bytes and turns them into HD44780 instruction/data transfers,
// tracking the cursor on a two-row display.
module uart_lcd_text_bridge
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] ROW1_BASE  = LCD_ROW1_BASE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_rs,
  output logic [7:0]                    cmd_byte,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(COLS);

  lcd_state_e     state_r;
  logic [7:0]     cur_byte_r;
  logic           row_r;
  logic [CW-1:0]  col_r;
  logic           need_addr_r;
  logic           cmd_valid_r;
  logic           cmd_rs_r;
  logic [7:0]     cmd_byte_r;

  logic [7:0]     fifo_rd_data_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           fifo_pop_s;
  logic           handshake_s;
  logic           col_last_s;
  logic [7:0]     addr_byte_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_valid),
    .wr_data (rx_data),
    .rd_en   (fifo_pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  assign rx_ready    = !fifo_full_s;
  assign fifo_pop_s  = (state_r == ST_IDLE) && !fifo_empty_s;
  assign handshake_s = cmd_valid_r && cmd_ready;
  assign col_last_s  = (col_r == CW'(COLS - 1));
  assign addr_byte_s = LCD_CMD_SET_DDRAM | (row_r ? ROW1_BASE : 8'h00) | 8'(col_r);
  assign busy        = !fifo_empty_s || (state_r != ST_IDLE);
  assign cmd_valid   = cmd_valid_r;
  assign cmd_rs      = cmd_rs_r;
  assign cmd_byte    = cmd_byte_r;

  // Each output state first raises cmd_valid, then waits for the handshake,
  // so a new transfer can never start in the cycle that completes the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_byte_r  <= 8'h00;
      row_r       <= 1'b0;
      col_r       <= {CW{1'b0}};
      need_addr_r <= 1'b1;
      cmd_valid_r <= 1'b0;
      cmd_rs_r    <= 1'b0;
      cmd_byte_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fifo_pop_s) begin
            cur_byte_r <= fifo_rd_data_s;
            state_r    <= ST_DECODE;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          if (is_printable(cur_byte_r)) begin
            state_r <= need_addr_r ? ST_ADDR : ST_CHAR;
          end else begin
            case (cur_byte_r)
              ASCII_CR: begin
                col_r       <= {CW{1'b0}};
                need_addr_r <= 1'b1;
                state_r     <= ST_IDLE;
              end
              ASCII_LF: begin
                row_r       <= ~row_r;
                col_r       <= {CW{1'b0}};
                need_addr_r <= 1'b1;
                state_r     <= ST_IDLE;
              end
              ASCII_FF: state_r <= ST_CLEAR;
              default:  state_r <= ST_IDLE;
            endcase
          end
        end
        ST_ADDR: begin
          if (!cmd_valid_r) begin
            cmd_valid_r <= 1'b1;
            cmd_rs_r    <= 1'b0;
            cmd_byte_r  <= addr_byte_s;
          end else if (handshake_s) begin
            cmd_valid_r <= 1'b0;
            need_addr_r <= 1'b0;
            state_r     <= ST_CHAR;
          end else begin
            state_r     <= ST_ADDR;
          end
        end
        ST_CHAR: begin
          if (!cmd_valid_r) begin
            cmd_valid_r <= 1'b1;
            cmd_rs_r    <= 1'b1;
            cmd_byte_r  <= cur_byte_r;
          end else if (handshake_s) begin
            cmd_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
            if (col_last_s) begin
              col_r       <= {CW{1'b0}};
              row_r       <= ~row_r;
              need_addr_r <= 1'b1;
            end else begin
              col_r       <= col_r + CW'(1);
            end
          end else begin
            state_r     <= ST_CHAR;
          end
        end
        ST_CLEAR: begin
          if (!cmd_valid_r) begin
            cmd_valid_r <= 1'b1;
            cmd_rs_r    <= 1'b0;
            cmd_byte_r  <= LCD_CMD_CLEAR;
          end else if (handshake_s) begin
            // Clear also homes the LCD address counter, so no address is needed next.
            cmd_valid_r <= 1'b0;
            row_r       <= 1'b0;
            col_r       <= {CW{1'b0}};
            need_addr_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_CLEAR;
          end
        end
        default: begin
          cmd_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_lcd_text_bridge.sv
// Directed bench for uart_lcd_text_bridge: a cursor model predicts LCD transfers
// into a queue, and a monitor checks every accepted transfer against it.
module tb_uart_lcd_text_bridge;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_byte;
  logic       busy;
  logic [4:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];
  int         m_row;
  int         m_col;
  bit         m_need;

  uart_lcd_text_bridge #(
    .COLS       (16),
    .FIFO_DEPTH (16),
    .ROW1_BASE  (8'h40)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rs     (cmd_rs),
    .cmd_byte   (cmd_byte),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row  = 0;
    m_col  = 0;
    m_need = 1'b1;
    exp_q.delete();
  endtask

  // Cursor model: predicts the transfers one received byte should cause.
  task automatic model_push(input logic [7:0] b);
    logic [7:0] a;
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_need) begin
        a = 8'h80 | ((m_row != 0) ? 8'h40 : 8'h00) | 8'(m_col);
        exp_q.push_back({1'b0, a});
        m_need = 1'b0;
      end
      exp_q.push_back({1'b1, b});
      if (m_col == 15) begin
        m_col  = 0;
        m_row  = 1 - m_row;
        m_need = 1'b1;
      end else begin
        m_col = m_col + 1;
      end
    end else if (b == 8'h0D) begin
      m_col  = 0;
      m_need = 1'b1;
    end else if (b == 8'h0A) begin
      m_row  = 1 - m_row;
      m_col  = 0;
      m_need = 1'b1;
    end else if (b == 8'h0C) begin
      exp_q.push_back({1'b0, 8'h01});
      m_row  = 0;
      m_col  = 0;
      m_need = 1'b0;
    end
  endtask

  // Accepted transfers are checked against the scoreboard in order.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && cmd_valid && cmd_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lcd_xfer", {23'd0, cmd_rs, cmd_byte}, {23'd0, e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!rx_ready && t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    if (rx_ready) begin
      rx_data  = b;
      rx_valid = 1'b1;
      model_push(b);
      @(posedge clk); #2;
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!cmd_valid && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    model_reset();
    reset_dut();

    // Reset state
    chk("rst_rx_ready",  32'(rx_ready),   32'd1);
    chk("rst_cmd_valid", 32'(cmd_valid),  32'd0);
    chk("rst_cmd_rs",    32'(cmd_rs),     32'd0);
    chk("rst_cmd_byte",  32'(cmd_byte),   32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_level",     32'(fifo_level), 32'd0);

    // Single character: address then data
    cmd_ready = 1'b1;
    send_byte(8'h41);
    wait_idle("single_a");

    // Row wrap 0 -> 1 -> 0
    reset_dut();
    for (int i = 0; i < 33; i++) begin
      send_byte(8'h61 + 8'(i % 26));
    end
    wait_idle("wrap");

    // CR and LF handling
    reset_dut();
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h0D);
    send_byte(8'h43);
    send_byte(8'h0A);
    send_byte(8'h44);
    send_byte(8'h07);
    wait_idle("cr_lf");

    // Clear held off by backpressure stays stable
    cmd_ready = 1'b0;
    send_byte(8'h0C);
    wait_valid("clr");
    for (int i = 0; i < 50; i++) begin
      chk("clr_hold_valid", 32'(cmd_valid), 32'd1);
      chk("clr_hold_byte",  32'(cmd_byte),  32'h01);
      chk("clr_hold_rs",    32'(cmd_rs),    32'd0);
      @(posedge clk); #2;
    end
    cmd_ready = 1'b1;
    send_byte(8'h45);
    wait_idle("clr_then_e");

    // FIFO fills while the LCD side is stalled
    reset_dut();
    cmd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'h61 + 8'(i));
    end
    repeat (3) @(posedge clk);
    #2;
    chk("full_level",    32'(fifo_level), 32'd16);
    chk("full_rx_ready", 32'(rx_ready),   32'd0);
    chk("full_busy",     32'(busy),       32'd1);
    cmd_ready = 1'b1;
    for (int i = 17; i < 20; i++) begin
      send_byte(8'h61 + 8'(i));
    end
    wait_idle("full_drain");

    // Reset in the middle of a pending transfer
    reset_dut();
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h41 + 8'(i));
    end
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(cmd_valid),  32'd1);
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    chk("mid_rst_valid",    32'(cmd_valid),  32'd0);
    chk("mid_rst_level",    32'(fifo_level), 32'd0);
    chk("mid_rst_rx_ready", 32'(rx_ready),   32'd1);
    chk("mid_rst_busy",     32'(busy),       32'd0);
    cmd_ready = 1'b1;
    send_byte(8'h41);
    wait_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
